// File: rtl/zvc_line_scheduler.sv
// Line scheduler for the zero-value compressor: accepts lines, issues them to the
// fixed-latency compressor, counts nonzero MT fields and buffers results in order.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting lines until num_lines have been taken
// DRAIN | all lines accepted, waiting for compressor and output buffer to empty
// DONE  | one-cycle completion pulse
module zvc_line_scheduler #(
    parameter int WORD_WIDTH    = 8,
    parameter int LINE_SIZE     = 32,
    parameter int DIST_WIDTH    = 7,
    parameter int MAX_LIFM_RSIZ = 3,
    parameter int COMP_LATENCY  = 2,
    parameter int OBUF_DEPTH    = 4
) (
    input  logic                                              clk,
    input  logic                                              reset_n,
    input  logic                                              start,
    input  logic [15:0]                                       num_lines,
    input  logic                                              in_valid,
    output logic                                              in_ready,
    input  logic [LINE_SIZE*WORD_WIDTH-1:0]                   lifm_line,
    input  logic [LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0]     mt_line,
    output logic                                              comp_issue,
    output logic [LINE_SIZE*WORD_WIDTH-1:0]                   comp_lifm_line,
    output logic [LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0]     comp_mt_line,
    input  logic [LINE_SIZE*WORD_WIDTH-1:0]                   comp_lifm,
    input  logic [LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0]     comp_mt,
    output logic                                              out_valid,
    input  logic                                              out_ready,
    output logic [LINE_SIZE*WORD_WIDTH-1:0]                   out_lifm,
    output logic [LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0]     out_mt,
    output logic [$clog2(LINE_SIZE+1)-1:0]                    out_nnz,
    output logic                                              busy,
    output logic                                              done
);

    localparam int MTW = DIST_WIDTH * MAX_LIFM_RSIZ;
    localparam int LW  = LINE_SIZE * WORD_WIDTH;
    localparam int MW  = LINE_SIZE * MTW;
    localparam int NW  = $clog2(LINE_SIZE + 1);
    localparam int PW  = $clog2(OBUF_DEPTH);
    localparam int CW  = $clog2(OBUF_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       num_lines_q;
    logic [15:0]       line_cnt_q;
    logic [CW-1:0]     in_flight_q;
    logic [CW-1:0]     fifo_cnt;
    logic [CW:0]       occ_sum;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              accept;
    logic              last_line;
    logic              fifo_push;
    logic              fifo_pop;
    logic [NW-1:0]     nnz_calc;
    logic [NW-1:0]     nnz_q;
    logic [COMP_LATENCY-1:0] dl_valid;
    logic [NW-1:0]     dl_nnz [COMP_LATENCY];

    logic [LW-1:0]     mem_lifm [OBUF_DEPTH];
    logic [MW-1:0]     mem_mt   [OBUF_DEPTH];
    logic [NW-1:0]     mem_nnz  [OBUF_DEPTH];

    // Each in-flight line holds a reserved buffer slot, so the buffer can never overflow.
    assign occ_sum   = {1'b0, in_flight_q} + {1'b0, fifo_cnt};
    assign in_ready  = (state_q == S_RUN) && (occ_sum < (CW+1)'(OBUF_DEPTH));
    assign accept    = in_valid && in_ready;
    assign last_line = (16'(line_cnt_q + 16'd1) == num_lines_q);
    assign fifo_push = dl_valid[COMP_LATENCY-1];
    assign out_valid = (fifo_cnt != '0);
    assign fifo_pop  = out_valid && out_ready;

    always_comb begin
        nnz_calc = '0;
        for (int i = 0; i < LINE_SIZE; i++) begin
            if (mt_line[i*MTW +: MTW] != '0) begin
                nnz_calc = nnz_calc + NW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (num_lines == 16'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (accept && last_line) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (in_flight_q == '0 && fifo_cnt == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            num_lines_q    <= '0;
            line_cnt_q     <= '0;
            in_flight_q    <= '0;
            fifo_cnt       <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            comp_issue     <= 1'b0;
            comp_lifm_line <= '0;
            comp_mt_line   <= '0;
            nnz_q          <= '0;
            dl_valid       <= '0;
            for (int i = 0; i < COMP_LATENCY; i++) begin
                dl_nnz[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start) begin
                num_lines_q <= num_lines;
                line_cnt_q  <= '0;
            end else if (accept) begin
                line_cnt_q <= line_cnt_q + 16'd1;
            end

            comp_issue <= accept;
            if (accept) begin
                comp_lifm_line <= lifm_line;
                comp_mt_line   <= mt_line;
                nnz_q          <= nnz_calc;
            end

            // nnz rides alongside the compressor so it lands with comp_lifm/comp_mt.
            dl_valid[0] <= comp_issue;
            dl_nnz[0]   <= nnz_q;
            for (int i = 1; i < COMP_LATENCY; i++) begin
                dl_valid[i] <= dl_valid[i-1];
                dl_nnz[i]   <= dl_nnz[i-1];
            end

            if (accept && !fifo_push) begin
                in_flight_q <= in_flight_q + CW'(1);
            end else if (!accept && fifo_push) begin
                in_flight_q <= in_flight_q - CW'(1);
            end

            if (fifo_push && !fifo_pop) begin
                fifo_cnt <= fifo_cnt + CW'(1);
            end else if (fifo_pop && !fifo_push) begin
                fifo_cnt <= fifo_cnt - CW'(1);
            end

            if (fifo_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            mem_lifm[wr_ptr] <= comp_lifm;
            mem_mt[wr_ptr]   <= comp_mt;
            mem_nnz[wr_ptr]  <= dl_nnz[COMP_LATENCY-1];
        end
    end

    assign out_lifm = out_valid ? mem_lifm[rd_ptr] : '0;
    assign out_mt   = out_valid ? mem_mt[rd_ptr]   : '0;
    assign out_nnz  = out_valid ? mem_nnz[rd_ptr]  : '0;

endmodule

// File: tb/tb_zvc_line_scheduler.sv
// Scoreboard bench for zvc_line_scheduler with a behavioural fixed-latency
// compressor (lifm inverted, mt passed through).
module tb_zvc_line_scheduler;

    localparam int WW  = 8;
    localparam int LS  = 32;
    localparam int DW  = 7;
    localparam int MR  = 3;
    localparam int CL  = 2;
    localparam int OD  = 4;
    localparam int MTW = DW * MR;
    localparam int LW  = LS * WW;
    localparam int MW  = LS * MTW;
    localparam int NW  = $clog2(LS + 1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   num_lines = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [LW-1:0] lifm_line = '0;
    logic [MW-1:0] mt_line = '0;
    logic          comp_issue;
    logic [LW-1:0] comp_lifm_line;
    logic [MW-1:0] comp_mt_line;
    logic [LW-1:0] comp_lifm;
    logic [MW-1:0] comp_mt;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [LW-1:0] out_lifm;
    logic [MW-1:0] out_mt;
    logic [NW-1:0] out_nnz;
    logic          busy;
    logic          done;

    zvc_line_scheduler #(
        .WORD_WIDTH(WW), .LINE_SIZE(LS), .DIST_WIDTH(DW),
        .MAX_LIFM_RSIZ(MR), .COMP_LATENCY(CL), .OBUF_DEPTH(OD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .num_lines(num_lines),
        .in_valid(in_valid), .in_ready(in_ready), .lifm_line(lifm_line), .mt_line(mt_line),
        .comp_issue(comp_issue), .comp_lifm_line(comp_lifm_line), .comp_mt_line(comp_mt_line),
        .comp_lifm(comp_lifm), .comp_mt(comp_mt),
        .out_valid(out_valid), .out_ready(out_ready), .out_lifm(out_lifm), .out_mt(out_mt),
        .out_nnz(out_nnz), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [LW-1:0] pipe_l [CL];
    logic [MW-1:0] pipe_m [CL];
    always @(posedge clk) begin
        pipe_l[0] <= comp_lifm_line;
        pipe_m[0] <= comp_mt_line;
        for (int i = 1; i < CL; i++) begin
            pipe_l[i] <= pipe_l[i-1];
            pipe_m[i] <= pipe_m[i-1];
        end
    end
    assign comp_lifm = ~pipe_l[CL-1];
    assign comp_mt   = pipe_m[CL-1];

    typedef struct {
        logic [LW-1:0] l;
        logic [MW-1:0] m;
        int            nnz;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    int            k_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    int            cur_k = 0;
    int            done_cnt = 0;
    int            issue_cnt = 0;
    int            ovalid_cnt = 0;
    int            acc_cnt = 0;
    bit            ovf_seen = 1'b0;
    bit            chk_lat = 1'b0;
    bit            tog_en = 1'b0;
    bit            prev_stall = 1'b0;
    logic [LW-1:0] held_l;
    logic [MW-1:0] held_m;
    logic [NW-1:0] held_n;
    logic [LW-1:0] last_acc_l = '0;
    logic [MW-1:0] last_acc_m = '0;

    task automatic check_val(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (tog_en) begin
            #1;
            out_ready = ~out_ready;
        end
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (dut.fifo_push && dut.fifo_cnt == OD) ovf_seen = 1'b1;
            if (done) begin
                done_cnt++;
                check_val("busy_in_done", 64'(busy), 64'd0);
            end
            if (comp_issue) begin
                issue_cnt++;
                check_val("comp_line", 64'(comp_lifm_line == last_acc_l && comp_mt_line == last_acc_m), 64'd1);
            end
            if (out_valid) ovalid_cnt++;
            if (prev_stall) begin
                check_val("out_stable", 64'(out_valid && out_lifm == held_l && out_mt == held_m && out_nnz == held_n), 64'd1);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_val("unexpected_out", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_val("out_lifm", 64'(out_lifm == e.l), 64'd1);
                    check_val("out_mt", 64'(out_mt == e.m), 64'd1);
                    check_val("out_nnz", 64'(out_nnz), 64'(e.nnz));
                    if (chk_lat) check_val("latency", 64'(cyc - e.cyc), 64'(CL + 2));
                    else check_val("latency_min", 64'((cyc - e.cyc) >= CL + 2), 64'd1);
                end
            end
            prev_stall = out_valid && !out_ready;
            held_l = out_lifm;
            held_m = out_mt;
            held_n = out_nnz;
            if (in_valid && in_ready) begin
                exp_t e;
                e.l = ~lifm_line;
                e.m = mt_line;
                e.nnz = cur_k;
                e.cyc = cyc;
                sb.push_back(e);
                last_acc_l = lifm_line;
                last_acc_m = mt_line;
                acc_cnt++;
            end
        end
    end

    // k nonzero fields scattered by a stride-7 permutation of the 32 field slots.
    task automatic make_line(int k);
        int seed;
        seed = $urandom_range(0, LS - 1);
        for (int j = 0; j < LW / 32; j++) lifm_line[j*32 +: 32] = $urandom;
        for (int i = 0; i < LS; i++) begin
            if (((i * 7 + seed) % LS) < k) mt_line[i*MTW +: MTW] = MTW'($urandom_range(1, (1 << MTW) - 1));
            else mt_line[i*MTW +: MTW] = '0;
        end
        cur_k = k;
    endtask

    task automatic drive_lines(int n);
        for (int i = 0; i < n; i++) begin
            bit acc;
            int wait_n;
            make_line((k_q.size() != 0) ? k_q.pop_front() : int'($urandom_range(0, LS)));
            in_valid = 1'b1;
            acc = 1'b0;
            wait_n = 0;
            while (!acc && wait_n < 200) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
                wait_n++;
            end
            if (!acc) check_val("accept_timeout", 64'd0, 64'd1);
        end
        in_valid = 1'b0;
    endtask

    task automatic start_frame(int n);
        @(posedge clk);
        #1;
        start = 1'b1;
        num_lines = 16'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic clear_counts();
        done_cnt = 0;
        issue_cnt = 0;
        ovalid_cnt = 0;
        acc_cnt = 0;
    endtask

    task automatic wait_done(int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        check_val("done_seen", 64'(seen), 64'd1);
    endtask

    task automatic frame_end(int lines);
        repeat (3) @(posedge clk);
        #1;
        check_val("done_once", 64'(done_cnt), 64'd1);
        check_val("lines_acc", 64'(acc_cnt), 64'(lines));
        check_val("issues", 64'(issue_cnt), 64'(lines));
        check_val("sb_empty", 64'(sb.size()), 64'd0);
        check_val("no_overflow", 64'(ovf_seen), 64'd0);
        check_val("idle_status", {61'd0, busy, done, in_ready}, 64'd0);
    endtask

    task automatic check_reset_vals();
        check_val("rst_ctrl", {59'd0, in_ready, comp_issue, out_valid, busy, done}, 64'd0);
        check_val("rst_data", 64'(comp_lifm_line == '0 && comp_mt_line == '0 &&
                                  out_lifm == '0 && out_mt == '0 && out_nnz == '0), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_vals();
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // three lines with 5/0/32 nonzero fields, full throughput
        clear_counts();
        out_ready = 1'b1;
        chk_lat = 1'b1;
        k_q = '{5, 0, 32};
        start_frame(3);
        drive_lines(3);
        wait_done(100);
        frame_end(3);
        check_val("outs_3", 64'(ovalid_cnt), 64'd3);
        chk_lat = 1'b0;

        // empty frame
        clear_counts();
        start_frame(0);
        @(negedge clk);
        check_val("zero_done", {62'd0, done, busy}, 64'd2);
        @(negedge clk);
        check_val("zero_done_drop", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        check_val("zero_issue", 64'(issue_cnt), 64'd0);
        check_val("zero_outv", 64'(ovalid_cnt), 64'd0);
        check_val("zero_done_once", 64'(done_cnt), 64'd1);

        // backpressure: buffer fills, then drains
        clear_counts();
        out_ready = 1'b0;
        start_frame(10);
        fork
            drive_lines(10);
            begin
                repeat (20) @(negedge clk);
                check_val("stall_acc", 64'(acc_cnt), 64'(OD));
                check_val("stall_ready", 64'(in_ready), 64'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_done(200);
        frame_end(10);

        // toggling out_ready with continuous input
        clear_counts();
        out_ready = 1'b1;
        tog_en = 1'b1;
        start_frame(12);
        drive_lines(12);
        wait_done(300);
        tog_en = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        frame_end(12);

        // reset mid-frame with two lines in flight
        clear_counts();
        start_frame(5);
        drive_lines(2);
        reset_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check_reset_vals();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        clear_counts();
        repeat (8) @(negedge clk);
        check_val("post_rst_outv", 64'(ovalid_cnt), 64'd0);
        check_val("post_rst_issue", 64'(issue_cnt), 64'd0);
        check_val("post_rst_busy", 64'(busy), 64'd0);
        start_frame(3);
        drive_lines(3);
        wait_done(100);
        frame_end(3);

        // start pulsed during RUN is ignored
        clear_counts();
        start_frame(4);
        fork
            drive_lines(4);
            begin
                @(posedge clk);
                #1;
                start = 1'b1;
                num_lines = 16'd9;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        join
        wait_done(100);
        frame_end(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/zvc_line_scheduler.md
ZVC_LINE_SCHEDULER -- requirements
Module: zvc_line_scheduler

Interface
REQ-001 Parameter WORD_WIDTH, default 8, bits per LIFM word.
REQ-002 Parameter LINE_SIZE, default 32, words per line.
REQ-003 Parameter DIST_WIDTH, default 7, bits per MT distance field.
REQ-004 Parameter MAX_LIFM_RSIZ, default 3, MT fields per word; MTW = DIST_WIDTH*MAX_LIFM_RSIZ.
REQ-005 Parameter COMP_LATENCY, default 2, fixed compressor latency in cycles, >=1.
REQ-006 Parameter OBUF_DEPTH, default 4, output buffer entries, power of two, >=2.
REQ-007 Clock and reset are fixed: one clock; reset is asynchronous and active-low.
REQ-008 Port clk, input, 1, rising-edge clock.
REQ-009 Port reset_n, input, 1, asynchronous active-low reset.
REQ-010 Port start, input, 1, single-cycle pulse that begins a frame; ignored unless IDLE.
REQ-011 Port num_lines, input, 16, lines in the frame, sampled on an accepted start.
REQ-012 Ports in_valid (input, 1), in_ready (output, 1), lifm_line (input, LINE_SIZE*WORD_WIDTH), mt_line (input, LINE_SIZE*MTW): line input handshake.
REQ-013 Ports comp_issue (output, 1), comp_lifm_line (output, LINE_SIZE*WORD_WIDTH), comp_mt_line (output, LINE_SIZE*MTW): registered drive to the compressor.
REQ-014 Ports comp_lifm (input, LINE_SIZE*WORD_WIDTH), comp_mt (input, LINE_SIZE*MTW): compressor result, valid COMP_LATENCY cycles after comp_issue.
REQ-015 Ports out_valid (output, 1), out_ready (input, 1), out_lifm, out_mt (outputs, compressor widths), out_nnz (output, $clog2(LINE_SIZE+1)): result handshake.
REQ-016 Ports busy (output, 1), done (output, 1): status.

Function
REQ-017 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE->RUN on start with num_lines!=0; IDLE->DONE on start with num_lines==0.
REQ-019 RUN->DRAIN in the cycle the last of num_lines lines is accepted.
REQ-020 DRAIN->DONE when in-flight count and buffer occupancy are both zero.
REQ-021 DONE->IDLE unconditionally after one cycle; done=1 only in DONE.
REQ-022 busy=1 in RUN and DRAIN, else 0.
REQ-023 in_ready=1 only in RUN and only when in_flight+occupancy < OBUF_DEPTH.
REQ-024 Line accepted when in_valid&&in_ready; the accepted line is registered onto comp_* with comp_issue=1 the next cycle; comp_issue=0 otherwise.
REQ-025 Per accepted line, nnz = count of MTW-bit mt_line fields that are nonzero, computed at acceptance.
REQ-026 nnz and a valid bit travel a COMP_LATENCY-stage delay line aligned with comp_issue; at its tail comp_lifm, comp_mt and nnz are written into the output FIFO.
REQ-027 in_flight increments on acceptance, decrements at FIFO write; both in the same cycle leaves it unchanged.
REQ-028 The FIFO never overflows; a FIFO write when full is a design error, flagged by a bench assertion.
REQ-029 out_valid = FIFO not empty; head pops on out_valid&&out_ready; simultaneous push and pop keeps occupancy constant; pointers wrap modulo OBUF_DEPTH.
REQ-030 out_* hold stable while out_valid=1 and out_ready=0.
REQ-031 Results leave in acceptance order; minimum acceptance-to-out_valid latency is COMP_LATENCY+2 cycles.
REQ-032 Line counter is 16 bits and never wraps; start in RUN, DRAIN or DONE is ignored.

Reset
REQ-033 While reset_n=0: state IDLE; counters, in_flight, FIFO pointers and delay-line valids cleared.
REQ-034 Reset values: in_ready=0, comp_issue=0, out_valid=0, busy=0, done=0, comp_*/out_* data=0.
REQ-035 Reset mid-frame discards all in-flight and buffered lines; a result arriving after reset release is not captured.

Verification
REQ-036 start, num_lines=3, in_valid=1, out_ready=1, three lines with 5/0/32 nonzero MT fields -> three outputs in order with out_nnz=5,0,32; done pulses once; busy falls with done.
REQ-037 start with num_lines=0 -> DONE on the next cycle, done=1 for one cycle, no comp_issue, no out_valid.
REQ-038 num_lines=10, out_ready=0 -> exactly OBUF_DEPTH=4 lines accepted, then in_ready=0; raise out_ready -> remaining 6 lines flow with no FIFO overflow.
REQ-039 out_ready toggling every cycle with continuous input -> no lost or duplicated output; out_* stable while stalled; order preserved.
REQ-040 reset_n low for one cycle with 2 lines in flight -> all outputs at reset values, out_valid=0 after release, next frame runs normally.
REQ-041 start pulsed during RUN -> ignored; line count and num_lines unchanged.
